// File: rtl/fisr_pkg.sv
// fisr_pkg: shared state type and float constants for the fast inverse square root sequencer
package fisr_pkg;
  typedef enum logic [2:0] {IDLE, SEED, MUL_YY, MUL_HX, SUB, MUL_Y, DONE} state_t;
  localparam logic [31:0] MAGIC_DEFAULT = 32'h5F3759DF;
  localparam logic [31:0] FP_ONE_HALF_3 = 32'h3FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_ZERO = 32'h00000000;
  // {hit, result}: zeros give +inf, negatives and NaN give qNaN, +inf gives zero
  function automatic logic [32:0] special_of(logic [31:0] x);
    return x[30:0] == 31'h0 ? {1'b1, FP_POS_INF} :
           (x[31] || (x[30:23] == 8'hFF && x[22:0] != 23'h0)) ? {1'b1, FP_QNAN} :
           x == FP_POS_INF ? {1'b1, FP_ZERO} : {1'b0, FP_ZERO};
  endfunction
endpackage

// File: rtl/fisr_lat_timer.sv
// fisr_lat_timer: loadable 3-bit down-counter flagging the last cycle of an operation state
module fisr_lat_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       last
);
  logic [2:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= 3'd0;
    else if (load) cnt <= load_val;
    else if (cnt != 3'd0) cnt <= cnt - 3'd1;
  assign last = cnt == 3'd0;
endmodule

// File: rtl/fisr_sequencer.sv
// fisr_sequencer: sequences seed + Newton steps of 1/sqrt(x) over external float mul/sub units.
// Define FISR_SPECIAL_EN to bypass zero, negative, NaN and +inf inputs straight to DONE.
module fisr_sequencer
  import fisr_pkg::*;
#(
  parameter int          MUL_LAT = 2,
  parameter int          SUB_LAT = 1,
  parameter int          ITER    = 1,
  parameter logic [31:0] MAGIC   = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        mul_ce,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  output logic        sub_ce,
  output logic [31:0] sub_a,
  output logic [31:0] sub_b,
  input  logic [31:0] sub_result,
  output logic        busy
);
  state_t state, next;
  logic [31:0] x, xh, y, t;
  logic [1:0] it;
  logic last, more;
`ifdef FISR_SPECIAL_EN
  logic [32:0] spec;
  assign spec = special_of(x);
`endif
  assign more = int'(it) + 1 < ITER;
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = in_valid ? SEED : IDLE;
`ifdef FISR_SPECIAL_EN
      SEED:    next = spec[32] ? DONE : MUL_YY;
`else
      SEED:    next = MUL_YY;
`endif
      MUL_YY:  next = last ? MUL_HX : MUL_YY;
      MUL_HX:  next = last ? SUB : MUL_HX;
      SUB:     next = last ? MUL_Y : SUB;
      MUL_Y:   next = last ? (more ? MUL_YY : DONE) : MUL_Y;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
    in_ready  = state == IDLE;
    busy      = state != IDLE;
    out_valid = state == DONE;
    out_data  = out_valid ? y : FP_ZERO;
    mul_ce    = state inside {MUL_YY, MUL_HX, MUL_Y};
    sub_ce    = state == SUB;
    mul_a     = state == MUL_HX ? xh : mul_ce ? y : FP_ZERO;
    mul_b     = state == MUL_YY ? y : mul_ce ? t : FP_ZERO;
    sub_a     = sub_ce ? FP_ONE_HALF_3 : FP_ZERO;
    sub_b     = sub_ce ? t : FP_ZERO;
  end
  // every state change reloads the shared timer for the state being entered
  fisr_lat_timer u_timer (
    .clk(clk),
    .rst(rst),
    .load(next != state),
    .load_val(next == SUB ? 3'(SUB_LAT - 1) : 3'(MUL_LAT - 1)),
    .last(last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      x  <= '0;
      xh <= '0;
      y  <= '0;
      t  <= '0;
      it <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) x <= in_data;
        SEED: begin
`ifdef FISR_SPECIAL_EN
          y  <= spec[32] ? spec[31:0] : MAGIC - (x >> 1);
`else
          y  <= MAGIC - (x >> 1);
`endif
          xh <= {x[31], x[30:23] - 8'd1, x[22:0]};
          it <= 2'd0;
        end
        MUL_YY: if (last) t <= mul_result;
        MUL_HX: if (last) t <= mul_result;
        SUB:    if (last) t <= sub_result;
        MUL_Y: if (last) begin
          y  <= mul_result;
          it <= it + 2'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: doc/fisr_sequencer.md
FISR_SEQUENCER -- requirements
Module: fisr_sequencer

Interface
REQ-001 Parameter MUL_LAT, default 2: fixed cycles from stable multiplier operands to valid mul_result, range 1..7.
REQ-002 Parameter SUB_LAT, default 1: fixed cycles from stable subtractor operands to valid sub_result, range 1..7.
REQ-003 Parameter ITER, default 1: Newton iterations per request, range 1..3.
REQ-004 Parameter MAGIC, default 32'h5F3759DF: seed constant.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  / in_ready  out  1 -- input handshake; in_data  in  32  IEEE-754 single x.
REQ-008 out_valid  out  1  / out_ready  in  1 -- output handshake; out_data  out  32  approximation of 1/sqrt(x).
REQ-009 mul_ce  out  1, mul_a  out  32, mul_b  out  32, mul_result  in  32 -- shared float multiplier port.
REQ-010 sub_ce  out  1, sub_a  out  32, sub_b  out  32, sub_result  in  32 -- float subtractor port computing sub_a - sub_b.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 States: IDLE, SEED, MUL_YY, MUL_HX, SUB, MUL_Y, DONE.
REQ-013 in_ready = 1 only in IDLE; a transfer (in_valid & in_ready) latches x and moves to SEED.
REQ-014 SEED (1 cycle): y <= MAGIC - (x >> 1) as 32-bit unsigned wrap subtraction; xh <= {x[31], x[30:23]-1, x[22:0]} (0.5*x); iteration count <= 0.
REQ-015 MUL_YY: mul_a=y, mul_b=y; t <= mul_result.
REQ-016 MUL_HX: mul_a=xh, mul_b=t; t <= mul_result.
REQ-017 SUB: sub_a=32'h3FC00000 (1.5), sub_b=t; t <= sub_result.
REQ-018 MUL_Y: mul_a=y, mul_b=t; y <= mul_result; iteration count +1; next MUL_YY if count < ITER, else DONE.
REQ-019 Each MUL_* state lasts exactly MUL_LAT cycles, SUB exactly SUB_LAT cycles; operands and ce held constant for the whole state; result captured on the state's final clock edge only; one shared latency counter.
REQ-020 mul_ce high only in MUL_* states, sub_ce high only in SUB; operands 0 elsewhere.
REQ-021 out_valid rises exactly 2 + ITER*(3*MUL_LAT+SUB_LAT) cycles after the accepting edge (9 with defaults).
REQ-022 DONE: out_valid=1, out_data=y; out_data stable while out_valid & !out_ready; transfer returns to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-023 xh exponent underflow (x exp = 0) wraps to 8'hFF without flagging unless REQ-027 applies.

Reset
REQ-024 rst forces IDLE from any state, including mid-operation; in-flight result discarded, no out_valid produced.
REQ-025 Reset values: in_ready=1 after the reset cycle, out_valid=0, out_data=0, busy=0, mul_ce=0, sub_ce=0, all operands 0, internal x/xh/y/t and counters 0.

Configuration
REQ-026 Macro FISR_SPECIAL_EN selects special-input bypass.
REQ-027 With FISR_SPECIAL_EN: at SEED, x==+0/-0 -> result 32'h7F800000; sign=1 (nonzero) or NaN -> 32'h7FC00000; +inf -> 32'h00000000; state goes SEED -> DONE directly (out_valid 2 cycles after accept), no mul_ce/sub_ce pulses.
REQ-028 Without FISR_SPECIAL_EN: all inputs take the full sequence of REQ-014..018 with identical latency; no special-case logic present.

Structure
REQ-029 Package fisr_pkg holds: state enum type, MAGIC default, FP_ONE_HALF_3 (32'h3FC00000), special-result constants (FP_POS_INF, FP_QNAN, FP_ZERO).
REQ-030 One sub-module fisr_lat_timer: loadable down-counter (3-bit) with "last" flag, used for all op states.

Verification
REQ-031 x=32'h3F800000 (1.0), defaults -> seed y=32'h3F7759DF, out_valid at cycle 9, out_data equals bit-exact golden model of the op sequence (~0.998).
REQ-032 x=32'h40800000 (4.0), ITER=2 -> seed 32'h3EF759DF, out_valid at 2+2*7=16 cycles, out_data matches golden, within 1e-5 of 0.5.
REQ-033 out_ready held low 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, no mul_ce pulses.
REQ-034 rst asserted during MUL_HX -> next cycle IDLE, mul_ce=0, out_valid never rises; following request completes with correct result.
REQ-035 FISR_SPECIAL_EN: x=0 -> 32'h7F800000; x=32'hBF800000 -> 32'h7FC00000; x=32'h7F800000 -> 0; each out_valid 2 cycles after accept; without macro, same inputs take 9 cycles.
REQ-036 Back-to-back in_valid held high, out_ready=1 -> one accept per 10 cycles, mul_ce never high in IDLE/SEED/DONE, operands constant within each op state.
